// File: rtl/raster_scan_counter.sv
// Raster pixel sequencer: walks an H_RES x V_RES grid in raster order and
// issues one (x, y) beat per valid/ready transfer, with frame counting.
//
// state  | meaning
// S_IDLE | no scan in progress, out_valid low
// S_RUN  | scanning, out_valid high, beat advances on each transfer
module raster_scan_counter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int XW    = $clog2(H_RES),
  parameter int YW    = $clog2(V_RES),
  parameter int FCW   = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           cont,
  input  logic           abort,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [XW-1:0]  x,
  output logic [YW-1:0]  y,
  output logic           sof,
  output logic           eol,
  output logic           eof,
  output logic           busy,
  output logic           frame_done,
  output logic [FCW-1:0] frame_cnt,
  output logic           frame_ovf
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t         r_state;
  logic           r_valid;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic           r_sof;
  logic           r_eol;
  logic           r_eof;
  logic           r_frame_done;
  logic [FCW-1:0] r_frame_cnt;
  logic           r_frame_ovf;

  logic w_xfer;
  logic w_x_end;
  logic w_y_end;
  logic w_x_pen;

  assign w_xfer  = r_valid & out_ready;
  assign w_x_end = (r_x == XW'(H_RES - 1));
  assign w_y_end = (r_y == YW'(V_RES - 1));
  assign w_x_pen = (r_x == XW'(H_RES - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_sof        <= 1'b0;
      r_eol        <= 1'b0;
      r_eof        <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_frame_ovf  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_ovf  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state <= S_RUN;
            r_valid <= 1'b1;
            r_x     <= '0;
            r_y     <= '0;
            r_sof   <= 1'b1;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
          end
        end
        S_RUN: begin
          // abort wins even over a coincident last-pixel transfer
          if (abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
          end else if (w_xfer) begin
            if (w_x_end && w_y_end) begin
              r_x          <= '0;
              r_y          <= '0;
              r_eol        <= 1'b0;
              r_eof        <= 1'b0;
              r_frame_done <= 1'b1;
              r_frame_cnt  <= r_frame_cnt + FCW'(1);
              r_frame_ovf  <= &r_frame_cnt;
              if (cont) begin
                r_sof <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_sof   <= 1'b0;
              end
            end else if (w_x_end) begin
              r_x   <= '0;
              r_y   <= r_y + YW'(1);
              r_sof <= 1'b0;
              r_eol <= 1'b0;
              r_eof <= 1'b0;
            end else begin
              r_x   <= r_x + XW'(1);
              r_sof <= 1'b0;
              r_eol <= w_x_pen;
              r_eof <= w_x_pen & w_y_end;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = r_valid;
  assign x          = r_x;
  assign y          = r_y;
  assign sof        = r_sof;
  assign eol        = r_eol;
  assign eof        = r_eof;
  assign busy       = (r_state == S_RUN);
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;
  assign frame_ovf  = r_frame_ovf;

endmodule

// File: tb/tb_raster_scan_counter.sv
// Directed bench for raster_scan_counter on a 4x3 grid with a 2-bit frame
// counter; outputs are sampled on the falling edge, inputs driven there too.
module tb_raster_scan_counter;
  localparam int H   = 4;
  localparam int V   = 3;
  localparam int N   = H * V;
  localparam int FCW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           cont;
  logic           abort;
  logic           out_ready;
  logic           out_valid;
  logic [1:0]     x;
  logic [1:0]     y;
  logic           sof;
  logic           eol;
  logic           eof;
  logic           busy;
  logic           frame_done;
  logic [FCW-1:0] frame_cnt;
  logic           frame_ovf;

  raster_scan_counter #(.H_RES(H), .V_RES(V), .FCW(FCW)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid), .x(x), .y(y),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .frame_ovf(frame_ovf)
  );

  always #5 clk = ~clk;

  // {valid, busy, x, y, sof, eol, eof, frame_done, frame_cnt, frame_ovf}
  logic [12:0] obs;
  assign obs = {out_valid, busy, x, y, sof, eol, eof, frame_done, frame_cnt, frame_ovf};

  int vecs = 0;
  int errs = 0;
  int exp_cnt = 0;

  function automatic logic [12:0] beat_vec(input int k, input bit fd, input int cnt, input bit ovf);
    return {1'b1, 1'b1, 2'(k % H), 2'((k / H) % V), (k % N) == 0, (k % H) == H - 1,
            (k % N) == N - 1, fd, 2'(cnt), ovf};
  endfunction

  function automatic logic [12:0] idle_vec(input bit fd, input int cnt, input bit ovf);
    return {2'b00, 2'd0, 2'd0, 3'b000, fd, 2'(cnt), ovf};
  endfunction

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; out_ready = 1'b0;
    #12;
    vecs++;
    if (obs !== 13'd0) begin
      errs++; $display("FAIL reset_assert: got %h expected %h", obs, 13'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    vecs++;
    if (obs !== 13'd0) begin
      errs++; $display("FAIL reset_release: got %h expected %h", obs, 13'd0);
    end
  endtask

  // Starts a scan of 'frames' frames; cont drops midway through the last one.
  task automatic scan(input string name, input int frames, input bit rnd);
    int k = 0;
    int budget = 0;
    bit pend = 0;
    bit efd;
    bit eovf;
    logic [12:0] e;
    cont = (frames > 1); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (k < frames * N && budget < 2000) begin
      efd = pend; eovf = 1'b0;
      if (pend) begin
        eovf = (exp_cnt == 3); exp_cnt = (exp_cnt + 1) % 4;
      end
      e = beat_vec(k, efd, exp_cnt, eovf);
      vecs++;
      if (obs !== e) begin
        errs++; $display("FAIL %s beat %0d: got %h expected %h", name, k, obs, e);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cont = (frames > 1) && (k < N * (frames - 1) + 6);
      pend = out_ready && ((k % N) == N - 1);
      if (out_ready) k++;
      budget++;
      @(negedge clk);
    end
    vecs++;
    if (budget >= 2000) begin
      errs++; $display("FAIL %s timeout: got %0d beats expected %0d", name, k, frames * N);
    end
    eovf = (exp_cnt == 3); exp_cnt = (exp_cnt + 1) % 4;
    e = idle_vec(1'b1, exp_cnt, eovf);
    vecs++;
    if (obs !== e) begin
      errs++; $display("FAIL %s done: got %h expected %h", name, obs, e);
    end
    out_ready = 1'b1; cont = 1'b0;
    @(negedge clk);
    e = idle_vec(1'b0, exp_cnt, 1'b0);
    vecs++;
    if (obs !== e) begin
      errs++; $display("FAIL %s after_done: got %h expected %h", name, obs, e);
    end
  endtask

  task automatic test_single;
    scan("single", 1, 1'b0);
  endtask

  task automatic test_stall;
    scan("stall", 1, 1'b1);
  endtask

  task automatic test_back_to_back;
    test_reset();
    scan("cont", 5, 1'b0);
  endtask

  task automatic test_start_ignored;
    logic [12:0] e;
    start = 1'b1; cont = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      e = beat_vec(k, 1'b0, exp_cnt, 1'b0);
      vecs++;
      if (obs !== e) begin
        errs++; $display("FAIL start_held beat %0d: got %h expected %h", k, obs, e);
      end
      if (k == N - 1) start = 1'b0;
      @(negedge clk);
    end
    exp_cnt = (exp_cnt + 1) % 4;
    e = idle_vec(1'b1, exp_cnt, 1'b0);
    vecs++;
    if (obs !== e) begin
      errs++; $display("FAIL start_held done: got %h expected %h", obs, e);
    end
    start = 1'b1; abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = idle_vec(1'b0, exp_cnt, 1'b0);
      vecs++;
      if (obs !== e) begin
        errs++; $display("FAIL start_abort_idle %0d: got %h expected %h", i, obs, e);
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_abort;
    logic [12:0] e;
    start = 1'b1; cont = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      e = beat_vec(k, 1'b0, exp_cnt, 1'b0);
      vecs++;
      if (obs !== e) begin
        errs++; $display("FAIL abort_mid beat %0d: got %h expected %h", k, obs, e);
      end
      if (k < 6) @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    e = idle_vec(1'b0, exp_cnt, 1'b0);
    vecs++;
    if (obs !== e) begin
      errs++; $display("FAIL abort_mid idle: got %h expected %h", obs, e);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      e = beat_vec(k, 1'b0, exp_cnt, 1'b0);
      vecs++;
      if (obs !== e) begin
        errs++; $display("FAIL abort_restart beat %0d: got %h expected %h", k, obs, e);
      end
      if (k == N - 1) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    e = idle_vec(1'b0, exp_cnt, 1'b0);
    vecs++;
    if (obs !== e) begin
      errs++; $display("FAIL abort_last idle: got %h expected %h", obs, e);
    end
    @(negedge clk);
    vecs++;
    if (obs !== e) begin
      errs++; $display("FAIL abort_last hold: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_rst_mid;
    start = 1'b1; cont = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_cnt = 0;
    vecs++;
    if (obs !== 13'd0) begin
      errs++; $display("FAIL rst_mid async: got %h expected %h", obs, 13'd0);
    end
    @(negedge clk);
    rst = 1'b0; cont = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++;
      if (obs !== 13'd0) begin
        errs++; $display("FAIL rst_mid idle %0d: got %h expected %h", i, obs, 13'd0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
